// File: rtl/sevenseg_scan_mux.sv
// sevenseg_scan_mux: four-digit multiplexed seven-segment driver
// with frame-synchronous display updates and leading-zero blanking.
module sevenseg_scan_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  segment,
  output logic        dp,
  output logic        frame_tick,
  output logic        bcd_err
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [3:0]    shadow_dp;
  logic [15:0]   disp;
  logic [3:0]    disp_dp;
  logic          pending;
  logic          slot_tick;
  logic          boundary;

  logic [3:0]    nib;
  logic [3:0]    blank;
  logic [6:0]    seg_on;
  logic          nib_bad;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign slot_tick = (presc == PW'(REFRESH_DIV - 1));
  assign boundary  = slot_tick && (idx == 2'd3);

  // prescaler and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_tick) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // shadow capture and frame-aligned display update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
      disp      <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
    end else if (boundary && load) begin
      disp    <= bcd_in;
      disp_dp <= dp_in;
      pending <= 1'b0;
    end else if (boundary && pending) begin
      disp    <= shadow;
      disp_dp <= shadow_dp;
      pending <= 1'b0;
    end else if (load) begin
      shadow    <= bcd_in;
      shadow_dp <= dp_in;
      pending   <= 1'b1;
    end
  end

  // active nibble and leading-zero blank mask
  always_comb begin
    nib = disp[3:0];
    case (idx)
      2'd0: nib = disp[3:0];
      2'd1: nib = disp[7:4];
      2'd2: nib = disp[11:8];
      2'd3: nib = disp[15:12];
      default: nib = disp[3:0];
    endcase
    blank    = 4'b0000;
    blank[3] = blank_lz && (disp[15:12] == 4'd0);
    blank[2] = blank[3] && (disp[11:8] == 4'd0);
    blank[1] = blank[2] && (disp[7:4] == 4'd0);
  end

  // BCD to active-high a..g
  always_comb begin
    seg_on  = 7'h00;
    nib_bad = 1'b0;
    case (nib)
      4'd0: seg_on = 7'h3F;
      4'd1: seg_on = 7'h06;
      4'd2: seg_on = 7'h5B;
      4'd3: seg_on = 7'h4F;
      4'd4: seg_on = 7'h66;
      4'd5: seg_on = 7'h6D;
      4'd6: seg_on = 7'h7D;
      4'd7: seg_on = 7'h07;
      4'd8: seg_on = 7'h7F;
      4'd9: seg_on = 7'h6F;
      default: nib_bad = 1'b1;
    endcase
  end

  // next output values for the active slot
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!blank[idx]) begin
      an_d      = 4'b1111;
      an_d[idx] = 1'b0;
      seg_d     = ~seg_on;
      dp_d      = ~disp_dp[idx];
    end
  end

  // registered, glitch-free outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= 4'b1111;
      segment    <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      an         <= an_d;
      segment    <= seg_d;
      dp         <= dp_d;
      frame_tick <= boundary;
      bcd_err    <= bcd_err | (nib_bad & ~blank[idx]);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// tb_sevenseg_scan_mux: directed frame-by-frame checks
// of scan order, decode, blanking, load timing and reset.
module tb_sevenseg_scan_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  segment;
  logic        dp;
  logic        frame_tick;
  logic        bcd_err;

  int total;
  int bad;

  sevenseg_scan_mux #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .an         (an),
    .segment    (segment),
    .dp         (dp),
    .frame_tick (frame_tick),
    .bcd_err    (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".an"}, {12'd0, an}, 16'h000F);
    chk({tag, ".seg"}, {9'd0, segment}, 16'h007F);
    chk({tag, ".dp"}, {15'd0, dp}, 16'h0001);
    chk({tag, ".ft"}, {15'd0, frame_tick}, 16'h0000);
    chk({tag, ".err"}, {15'd0, bcd_err}, 16'h0000);
  endtask

  // One 16-clock frame. s0..s3: expected active-low segments per slot,
  // dpl: expected dp per slot, bl: slots expected blanked.
  // Optional loads (la/lb = edge index 0..15, -1 none).
  task automatic run_frame(
    input string tag,
    input logic [6:0] s0, input logic [6:0] s1,
    input logic [6:0] s2, input logic [6:0] s3,
    input logic [3:0] dpl, input logic [3:0] bl,
    input int la, input logic [15:0] va,
    input int lb, input logic [15:0] vb);
    logic [6:0] sx [4];
    logic [3:0] ea;
    sx[0] = s0; sx[1] = s1; sx[2] = s2; sx[3] = s3;
    for (int e = 0; e < 16; e++) begin
      int k;
      k = e / 4;
      if (e == la) begin load = 1'b1; bcd_in = va; end
      if (e == lb) begin load = 1'b1; bcd_in = vb; end
      step();
      load = 1'b0;
      ea = 4'b1111;
      if (!bl[k]) ea[k] = 1'b0;
      chk($sformatf("%s.e%0d.an", tag, e), {12'd0, an}, {12'd0, ea});
      chk($sformatf("%s.e%0d.seg", tag, e), {9'd0, segment},
          bl[k] ? 16'h007F : {9'd0, sx[k]});
      chk($sformatf("%s.e%0d.dp", tag, e), {15'd0, dp},
          bl[k] ? 16'h0001 : {15'd0, dpl[k]});
      chk($sformatf("%s.e%0d.ft", tag, e), {15'd0, frame_tick},
          (e == 15) ? 16'h0001 : 16'h0000);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    bcd_in   = '0;
    dp_in    = '0;
    load     = 1'b0;
    blank_lz = 1'b0;
    step();
    step();
    chk_reset("rst0");
    rst_n = 1'b1;

    run_frame("f0_idle", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 4'h0,
              -1, 16'h0, -1, 16'h0);

    dp_in = 4'b0100;
    run_frame("f1_hold", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 4'h0,
              4, 16'h1234, -1, 16'h0);
    dp_in = 4'b0000;

    run_frame("f2_1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1011, 4'h0,
              -1, 16'h0, -1, 16'h0);

    blank_lz = 1'b1;
    run_frame("f3_lz1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1011, 4'h0,
              2, 16'h0070, -1, 16'h0);

    run_frame("f4_0070", 7'h40, 7'h78, 7'h7F, 7'h7F, 4'hF, 4'b1100,
              5, 16'h000A, -1, 16'h0);
    chk("err_before_A", {15'd0, bcd_err}, 16'h0000);

    blank_lz = 1'b0;
    run_frame("f5_000A", 7'h7F, 7'h40, 7'h40, 7'h40, 4'hF, 4'h0,
              3, 16'h0000, -1, 16'h0);
    chk("err_set", {15'd0, bcd_err}, 16'h0001);

    run_frame("f6_0000", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 4'h0,
              2, 16'h1111, 8, 16'h2222);
    chk("err_sticky", {15'd0, bcd_err}, 16'h0001);

    run_frame("f7_2222", 7'h24, 7'h24, 7'h24, 7'h24, 4'hF, 4'h0,
              15, 16'h9999, -1, 16'h0);

    run_frame("f8_9999", 7'h10, 7'h10, 7'h10, 7'h10, 4'hF, 4'h0,
              -1, 16'h0, -1, 16'h0);

    for (int e = 0; e < 6; e++) begin
      if (e == 3) begin load = 1'b1; bcd_in = 16'h3333; end
      step();
      load = 1'b0;
    end
    rst_n = 1'b0;
    step();
    chk_reset("rst_mid");
    rst_n = 1'b1;

    run_frame("f9_post", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 4'h0,
              -1, 16'h0, -1, 16'h0);
    run_frame("f10_post", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 4'h0,
              -1, 16'h0, -1, 16'h0);
    chk("err_after_rst", {15'd0, bcd_err}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_mux.md
SEVENSEG_SCAN_MUX -- requirements
Module: sevenseg_scan_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 Port list SHALL be, clock and reset first:
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- bcd_in  input  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- dp_in  input  4  decimal point request per digit, active high; bit i for digit i.
- load  input  1  one-cycle strobe; captures bcd_in/dp_in.
- blank_lz  input  1  level; 1 enables leading-zero blanking.
- an  output  4  digit enables, active low; an[i] drives digit i.
- segment  output  7  segments a..g on [0]..[6], active low.
- dp  output  1  decimal point, active low.
- frame_tick  output  1  one-cycle pulse at each frame boundary.
- bcd_err  output  1  sticky flag; set when a displayed nibble is >9.

Function
REQ-003 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; its terminal count is slot_tick.
REQ-004 On slot_tick, digit index SHALL advance 0->1->2->3->0; a frame boundary is the slot_tick where index goes 3->0.
REQ-005 load SHALL capture bcd_in/dp_in into a shadow register and set pending; a later load before the boundary overwrites the shadow (last load wins).
REQ-006 At a frame boundary with pending=1, the display register SHALL take the shadow value and clear pending; the display register never changes mid-frame.
REQ-007 If load coincides with a frame boundary, the load data SHALL go straight to the display register, and pending SHALL end at 0.
REQ-008 frame_tick SHALL pulse exactly one cycle, in the cycle after each frame boundary.
REQ-009 Decode, active-high a..g, then inverted on output:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- nibble 10..15 -> all segments off, and bcd_err set.
REQ-010 With blank_lz=1, digit k (k=3,2,1) SHALL be blanked when its nibble and every higher nibble are 0.
- Blanked digit: an[k]=1, segment=7'h7F, dp=1.
- Digit 0 is never blanked.
- With blank_lz=0, no digit is blanked.
REQ-011 For the active unblanked digit i: an is one-hot-low at bit i, and dp = ~display_dp[i].
REQ-012 an, segment and dp SHALL be registered, updating one cycle after the index or display register changes; no glitches between slots.
REQ-013 bcd_err SHALL stay 1 once set, and clear only on reset.
REQ-014 blank_lz SHALL be sampled every cycle; a change takes effect at the next output register update.

Reset
REQ-015 While rst_n=0 at a rising edge, the block SHALL set:
- prescaler=0, index=0, display register=0, shadow=0, pending=0
- an=4'b1111, segment=7'h7F, dp=1, frame_tick=0, bcd_err=0.
REQ-016 Reset asserted mid-frame SHALL discard shadow and pending data.
REQ-017 After rst_n rises, the first slot (digit 0) SHALL start with prescaler=0, and an=4'b1110 appears the next cycle.

Verification (REFRESH_DIV=4)
REQ-018 Reset then idle -> an cycles 1110,1101,1011,0111 for 4 clk each; segment=7'h40 (digit "0", active low) in every slot; frame_tick every 16 clk.
REQ-019 load bcd_in=16'h1234, dp_in=4'b0100 mid-frame -> display unchanged until next frame_tick; then digit 0=4 (7'h19), digit 3=1 (7'h79), dp=0 only while an=1011.
REQ-020 blank_lz=1, load 16'h0070 -> an never shows 0111 or 1011; digit1=7 (7'h78); digit0=0 (7'h40).
REQ-021 load 16'h000A -> digit 0 segment=7'h7F; bcd_err=1 and stays 1 after loading 16'h0000.
REQ-022 load 16'h1111 then 16'h2222 in the same frame -> the next frame shows 2222; load landing on the boundary cycle -> that value shows in the same new frame.
REQ-023 rst_n=0 for 1 cycle mid-frame with a load pending -> outputs return to REQ-015 values; the pending value never appears.
